// File: rtl/drid_tracker_pkg.sv
// Shared sizing and entry layout for the directory request-ID tracker.
// Imported by the tracker top and its free-ID picker.
package drid_tracker_pkg;

    localparam int DR_REQIDS    = 64;
    localparam int DR_REQIDBITS = 6;

    typedef struct packed {
        logic [4:0] nid;
        logic [5:0] l2id;
    } I_drid_entry_type;

endpackage

// File: rtl/drid_pick_free.sv
// Lowest-set-bit priority encoder with an any-set flag.
// Shared by the DRID allocator and future snoop-ID allocators.
module drid_pick_free #(
    parameter int N = 64,
    parameter int W = 6
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
        end
    end

    assign any = |vec;

endmodule

// File: rtl/drid_tracker.sv
// Allocates DRIDs to L2 requests and returns the recorded
// node/L2 IDs when memory acks, freeing the DRID.
module drid_tracker
    import drid_tracker_pkg::*;
#(
    parameter int NUM_IDS   = DR_REQIDS,
    parameter int ID_BITS   = DR_REQIDBITS,
    parameter int NID_BITS  = 5,
    parameter int L2ID_BITS = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alloc_valid,
    output logic                 alloc_retry,
    input  logic [NID_BITS-1:0]  alloc_nid,
    input  logic [L2ID_BITS-1:0] alloc_l2id,
    output logic [ID_BITS-1:0]   alloc_drid,
    input  logic                 rel_valid,
    output logic                 rel_retry,
    input  logic [ID_BITS-1:0]   rel_drid,
    output logic                 rsp_valid,
    input  logic                 rsp_retry,
    output logic [NID_BITS-1:0]  rsp_nid,
    output logic [L2ID_BITS-1:0] rsp_l2id,
    output logic [ID_BITS-1:0]   rsp_drid,
    output logic [ID_BITS:0]     outstanding,
    output logic                 err_bad_release
);

    localparam int ENT_W = NID_BITS + L2ID_BITS;

    logic [NUM_IDS-1:0] free_q;
    logic [NUM_IDS-1:0] free_d;
    logic [ID_BITS-1:0] pick_idx;
    logic               pick_any;
    logic               alloc_fire;
    logic               rel_fire;
    logic               rel_ok;
    logic [ENT_W-1:0]   mem [NUM_IDS];

    drid_pick_free #(
        .N (NUM_IDS),
        .W (ID_BITS)
    ) u_pick (
        .vec (free_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Grant comes from the registered vector only, so a DRID
    // released this cycle is never handed out in the same cycle.
    assign alloc_retry = !pick_any;
    assign alloc_drid  = pick_idx;
    assign alloc_fire  = alloc_valid && pick_any;

    assign rel_retry = rsp_valid && rsp_retry;
    assign rel_fire  = rel_valid && !rel_retry;
    assign rel_ok    = rel_fire && (rel_drid != '0)
                     && !free_q[rel_drid];

    always_comb begin
        free_d = free_q;
        if (alloc_fire) free_d[pick_idx] = 1'b0;
        if (rel_ok)     free_d[rel_drid] = 1'b1;
        free_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            free_q <= {{(NUM_IDS-1){1'b1}}, 1'b0};
        end else begin
            free_q <= free_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) mem[pick_idx] <= {alloc_nid, alloc_l2id};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_nid   <= '0;
            rsp_l2id  <= '0;
            rsp_drid  <= '0;
        end else if (rel_ok) begin
            rsp_valid <= 1'b1;
            {rsp_nid, rsp_l2id} <= mem[rel_drid];
            rsp_drid  <= rel_drid;
        end else if (!rsp_retry) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding <= '0;
        end else begin
            unique case ({alloc_fire, rel_ok})
                2'b10:   outstanding <= outstanding + (ID_BITS+1)'(1);
                2'b01:   outstanding <= outstanding - (ID_BITS+1)'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_bad_release <= 1'b0;
        end else if (rel_fire && !rel_ok) begin
            err_bad_release <= 1'b1;
        end
    end

endmodule

// File: tb/tb_drid_tracker.sv
// Directed bench for drid_tracker; releases push expected
// responses that a negedge monitor pops and compares.
module tb_drid_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic       alloc_valid;
    logic       alloc_retry;
    logic [4:0] alloc_nid;
    logic [5:0] alloc_l2id;
    logic [5:0] alloc_drid;
    logic       rel_valid;
    logic       rel_retry;
    logic [5:0] rel_drid;
    logic       rsp_valid;
    logic       rsp_retry;
    logic [4:0] rsp_nid;
    logic [5:0] rsp_l2id;
    logic [5:0] rsp_drid;
    logic [6:0] outstanding;
    logic       err_bad_release;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0]  tnid [64];
    logic [5:0]  tl2  [64];
    logic [16:0] sb [$];
    logic        held = 1'b0;
    logic [16:0] hold_v;

    drid_tracker dut (
        .clk             (clk),
        .reset           (reset),
        .alloc_valid     (alloc_valid),
        .alloc_retry     (alloc_retry),
        .alloc_nid       (alloc_nid),
        .alloc_l2id      (alloc_l2id),
        .alloc_drid      (alloc_drid),
        .rel_valid       (rel_valid),
        .rel_retry       (rel_retry),
        .rel_drid        (rel_drid),
        .rsp_valid       (rsp_valid),
        .rsp_retry       (rsp_retry),
        .rsp_nid         (rsp_nid),
        .rsp_l2id        (rsp_l2id),
        .rsp_drid        (rsp_drid),
        .outstanding     (outstanding),
        .err_bad_release (err_bad_release)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_alloc(input logic [4:0] nid,
                            input logic [5:0] l2id,
                            input logic [5:0] exp_drid);
        alloc_valid = 1'b1;
        alloc_nid   = nid;
        alloc_l2id  = l2id;
        @(negedge clk);
        chk("alloc_retry", 32'(alloc_retry), 32'd0);
        chk("alloc_drid", 32'(alloc_drid), 32'(exp_drid));
        tnid[exp_drid] = nid;
        tl2[exp_drid]  = l2id;
        @(posedge clk);
        #1;
        alloc_valid = 1'b0;
    endtask

    task automatic do_rel(input logic [5:0] drid, input logic ok);
        rel_valid = 1'b1;
        rel_drid  = drid;
        @(negedge clk);
        chk("rel_retry", 32'(rel_retry), 32'd0);
        if (ok) sb.push_back({tnid[drid], tl2[drid], drid});
        @(posedge clk);
        #1;
        rel_valid = 1'b0;
    endtask

    // Response monitor: checks hold stability and pops on handshake
    always @(negedge clk) begin
        if (!reset) begin
            held = 1'b0;
        end else begin
            if (rsp_valid && held)
                chk("rsp_stable", 32'({rsp_nid, rsp_l2id, rsp_drid}),
                    32'(hold_v));
            if (rsp_valid && !rsp_retry) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got drid %0d expected none",
                             rsp_drid);
                end else begin
                    chk("rsp_payload",
                        32'({rsp_nid, rsp_l2id, rsp_drid}),
                        32'(sb.pop_front()));
                end
            end
            held   = rsp_valid && rsp_retry;
            hold_v = {rsp_nid, rsp_l2id, rsp_drid};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset       = 1'b0;
        alloc_valid = 1'b0;
        alloc_nid   = '0;
        alloc_l2id  = '0;
        rel_valid   = 1'b0;
        rel_drid    = '0;
        rsp_retry   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alloc_retry", 32'(alloc_retry), 32'd0);
        chk("rst_alloc_drid", 32'(alloc_drid), 32'd1);
        chk("rst_rel_retry", 32'(rel_retry), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_pay", 32'({rsp_nid, rsp_l2id, rsp_drid}), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_err", 32'(err_bad_release), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        do_alloc(5'd3, 6'd10, 6'd1);
        do_alloc(5'd3, 6'd11, 6'd2);
        do_alloc(5'd3, 6'd12, 6'd3);
        chk("out_after3", 32'(outstanding), 32'd3);

        do_rel(6'd2, 1'b1);
        do_alloc(5'd7, 6'd20, 6'd2);
        chk("out_realloc", 32'(outstanding), 32'd3);

        for (int i = 4; i < 64; i++)
            do_alloc(5'(i), 6'(63 - i), 6'(i));
        @(negedge clk);
        chk("full_retry", 32'(alloc_retry), 32'd1);
        chk("full_out", 32'(outstanding), 32'd63);

        // Blocked alloc alongside a release of 40
        @(posedge clk);
        #1;
        alloc_valid = 1'b1;
        alloc_nid   = 5'd9;
        alloc_l2id  = 6'd33;
        rel_valid   = 1'b1;
        rel_drid    = 6'd40;
        @(negedge clk);
        chk("full_blocked", 32'(alloc_retry), 32'd1);
        sb.push_back({tnid[40], tl2[40], 6'd40});
        @(posedge clk);
        #1;
        rel_valid = 1'b0;
        @(negedge clk);
        chk("regrant_retry", 32'(alloc_retry), 32'd0);
        chk("regrant_drid", 32'(alloc_drid), 32'd40);
        tnid[40] = 5'd9;
        tl2[40]  = 6'd33;
        @(posedge clk);
        #1;
        alloc_valid = 1'b0;
        chk("out_full_again", 32'(outstanding), 32'd63);

        // Downstream stall holds the response and blocks releases
        rsp_retry = 1'b1;
        do_rel(6'd10, 1'b1);
        rel_valid = 1'b1;
        rel_drid  = 6'd11;
        @(negedge clk);
        chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("stall_rel_retry", 32'(rel_retry), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("stall_rel_retry2", 32'(rel_retry), 32'd1);
        @(posedge clk);
        #1;
        rsp_retry = 1'b0;
        @(negedge clk);
        chk("unstall_rel_retry", 32'(rel_retry), 32'd0);
        sb.push_back({tnid[11], tl2[11], 6'd11});
        @(posedge clk);
        #1;
        rel_valid = 1'b0;
        chk("out_after_stall", 32'(outstanding), 32'd61);

        do_rel(6'd5, 1'b1);
        chk("err_before", 32'(err_bad_release), 32'd0);
        do_rel(6'd0, 1'b0);
        do_rel(6'd5, 1'b0);
        @(negedge clk);
        chk("bad_no_rsp", 32'(rsp_valid), 32'd0);
        chk("bad_out", 32'(outstanding), 32'd60);
        chk("bad_err", 32'(err_bad_release), 32'd1);
        @(posedge clk);
        #1;

        // Reset while a response is stalled
        rsp_retry = 1'b1;
        do_rel(6'd20, 1'b1);
        chk("pend_rsp_valid", 32'(rsp_valid), 32'd1);
        reset = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_out", 32'(outstanding), 32'd0);
        chk("mid_rst_err", 32'(err_bad_release), 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        rsp_retry = 1'b0;
        do_alloc(5'd1, 6'd2, 6'd1);
        chk("post_rst_out", 32'(outstanding), 32'd1);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
